pc_ras_unit: RTL and testbench

- Parametrised successor to the 8-bit program counter and branch-control pair.
- Holds the program counter and selects the next PC: increment, taken branch, subroutine call, or return.
- Adds a hardware return-address stack (RAS), so nested subroutine calls no longer rely on a single link register.
- Sits at the front of the fetch path and drives the instruction-memory address directly.

---
 rtl/pc_ras_unit.sv | 117 +++++++++++
 tb/tb_pc_ras_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection (increment, branch, call, return)
// and a circular return-address stack that drives the fetch address.
module pc_ras_unit #(
    parameter int             AW        = 8,
    parameter int             RAS_DEPTH = 4,
    parameter logic [AW-1:0]  RST_VEC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           br_taken,
    input  logic                           call,
    input  logic                           ret,
    input  logic [AW-1:0]                  br_target,
    output logic [AW-1:0]                  pc,
    output logic [AW-1:0]                  ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_ovf,
    output logic                           ras_udf
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [AW-1:0] stack [RAS_DEPTH];
    logic [PW-1:0] tp, tp_inc, tp_dec, tp_nxt;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] pc_inc, pc_nxt;
    logic          full, empty;
    logic          push, pop, replace, set_ovf, set_udf;

    assign pc_inc  = pc + AW'(1);
    assign full    = (ras_count == CW'(RAS_DEPTH));
    assign empty   = (ras_count == '0);
    // The stored value under tp is stale once the stack drains, so mask it.
    assign ras_top = empty ? '0 : stack[tp];

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    always_comb begin
        tp_inc = (tp == PW'(RAS_DEPTH - 1)) ? '0 : tp + PW'(1);
        tp_dec = (tp == '0) ? PW'(RAS_DEPTH - 1) : tp - PW'(1);
    end

    // Next-PC selection and stack operation decode; call/ret override br_taken.
    always_comb begin
        pc_nxt  = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        set_udf = 1'b0;
        if (call && ret) begin
            pc_nxt = br_target;
            if (empty) begin
                // Tail call with nothing to return from degrades to a call.
                push    = 1'b1;
                set_udf = 1'b1;
            end else begin
                replace = 1'b1;
            end
        end else if (call) begin
            pc_nxt = br_target;
            push   = 1'b1;
        end else if (ret) begin
            if (empty) begin
                set_udf = 1'b1;
            end else begin
                pc_nxt = stack[tp];
                pop    = 1'b1;
            end
        end else if (br_taken) begin
            pc_nxt = br_target;
        end
        set_ovf = push && full;
    end

    // Pointer and occupancy update; a push while full overwrites the oldest
    // slot, which is simply the next slot around the ring.
    always_comb begin
        tp_nxt    = tp;
        count_nxt = ras_count;
        if (push) begin
            tp_nxt = tp_inc;
            if (!full) count_nxt = ras_count + CW'(1);
        end else if (pop) begin
            tp_nxt    = tp_dec;
            count_nxt = ras_count - CW'(1);
        end
    end

    // Control state: PC, pointer, count and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RST_VEC;
            tp        <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_udf   <= 1'b0;
        end else if (en) begin
            pc        <= pc_nxt;
            tp        <= tp_nxt;
            ras_count <= count_nxt;
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_udf) ras_udf <= 1'b1;
        end
    end

    // Stack storage needs no reset; entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (!rst && en) begin
            if (push)
                stack[tp_inc] <= pc_inc;
            else if (replace)
                stack[tp] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: directed vectors push hand-computed
// expected state; a monitor pops and compares one cycle after each edge.
module tb_pc_ras_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       br_taken = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] br_target = '0;
    logic [7:0] pc, ras_top, pc2, ras_top2;
    logic [2:0] ras_count, ras_count2;
    logic       ras_ovf, ras_udf, ras_ovf2, ras_udf2;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] top;
        logic [2:0] cnt;
        logic       ovf;
        logic       udf;
        logic       chk2;
        logic [7:0] pc2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_ras_unit #(.AW(8), .RAS_DEPTH(4), .RST_VEC(8'h00)) u_dut (
        .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .call(call),
        .ret(ret), .br_target(br_target), .pc(pc), .ras_top(ras_top),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
    );

    pc_ras_unit #(.AW(8), .RAS_DEPTH(4), .RST_VEC(8'hF0)) u_dut_f0 (
        .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .call(call),
        .ret(ret), .br_target(br_target), .pc(pc2), .ras_top(ras_top2),
        .ras_count(ras_count2), .ras_ovf(ras_ovf2), .ras_udf(ras_udf2)
    );

    task automatic apply(input logic r, input logic e, input logic b,
                         input logic c, input logic rt, input logic [7:0] tgt,
                         input logic [7:0] xpc, input logic [7:0] xtop,
                         input logic [2:0] xcnt, input logic xovf, input logic xudf,
                         input logic xchk2 = 1'b0, input logic [7:0] xpc2 = 8'h00);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; br_taken = b; call = c; ret = rt; br_target = tgt;
        x.pc = xpc; x.top = xtop; x.cnt = xcnt; x.ovf = xovf; x.udf = xudf;
        x.chk2 = xchk2; x.pc2 = xpc2;
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle with an outstanding expectation is checked.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_vec++;
            if (pc !== x.pc) begin
                n_err++;
                $display("FAIL pc vec%0d: got %h want %h", n_vec, pc, x.pc);
            end
            if (ras_top !== x.top) begin
                n_err++;
                $display("FAIL ras_top vec%0d: got %h want %h", n_vec, ras_top, x.top);
            end
            if (ras_count !== x.cnt) begin
                n_err++;
                $display("FAIL ras_count vec%0d: got %0d want %0d", n_vec, ras_count, x.cnt);
            end
            if (ras_ovf !== x.ovf) begin
                n_err++;
                $display("FAIL ras_ovf vec%0d: got %b want %b", n_vec, ras_ovf, x.ovf);
            end
            if (ras_udf !== x.udf) begin
                n_err++;
                $display("FAIL ras_udf vec%0d: got %b want %b", n_vec, ras_udf, x.udf);
            end
            if (x.chk2 && (pc2 !== x.pc2)) begin
                n_err++;
                $display("FAIL pc_rstvec vec%0d: got %h want %h", n_vec, pc2, x.pc2);
            end
        end
    end

    initial begin
        //    rst en br cl rt tgt     pc     top    cnt ovf udf
        apply(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 8'hF0);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0, 1, 8'hF1);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h02, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h03, 8'h00, 0, 0, 0);
        apply(0, 1, 1, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);   // wrap
        apply(0, 1, 1, 0, 0, 8'h40, 8'h40, 8'h00, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 8'h55, 8'h40, 8'h00, 0, 0, 0);   // stall
        // nested calls
        apply(0, 1, 1, 0, 0, 8'h10, 8'h10, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h20, 8'h20, 8'h11, 1, 0, 0);
        apply(0, 1, 1, 1, 0, 8'h30, 8'h30, 8'h21, 2, 0, 0);   // br ignored
        apply(0, 1, 0, 0, 1, 8'h00, 8'h21, 8'h11, 1, 0, 0);
        apply(0, 1, 1, 0, 1, 8'h77, 8'h11, 8'h00, 0, 0, 0);   // br ignored
        // tail call
        apply(0, 1, 1, 0, 0, 8'h10, 8'h10, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h30, 8'h30, 8'h11, 1, 0, 0);
        apply(0, 1, 0, 1, 1, 8'h50, 8'h50, 8'h31, 1, 0, 0);
        apply(0, 0, 0, 1, 0, 8'h77, 8'h50, 8'h31, 1, 0, 0);   // stalled call
        apply(0, 1, 0, 0, 1, 8'h00, 8'h31, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h32, 8'h00, 0, 0, 1);   // underflow
        // overflow
        apply(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 8'hF0);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h02, 8'h02, 8'h02, 1, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h03, 8'h03, 8'h03, 2, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h04, 8'h04, 8'h04, 3, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h05, 8'h05, 8'h05, 4, 0, 0);
        apply(0, 1, 0, 1, 0, 8'h06, 8'h06, 8'h06, 4, 1, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h06, 8'h05, 3, 1, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h05, 8'h04, 2, 1, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h04, 8'h03, 1, 1, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h03, 8'h00, 0, 1, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h04, 8'h00, 0, 1, 1);
        // call+ret on empty stack acts as a call
        apply(0, 1, 0, 1, 1, 8'h70, 8'h70, 8'h05, 1, 1, 1);
        apply(0, 1, 0, 1, 0, 8'h71, 8'h71, 8'h71, 2, 1, 1);
        apply(0, 1, 0, 1, 0, 8'h72, 8'h72, 8'h72, 3, 1, 1);
        // reset beats a simultaneous call
        apply(1, 1, 0, 1, 0, 8'h99, 8'h00, 8'h00, 0, 0, 0, 1, 8'hF0);
        apply(0, 1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        apply(0, 1, 0, 0, 1, 8'h00, 8'h02, 8'h00, 0, 0, 1);
        // reset during a stall
        apply(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 8'hF0);
        @(negedge clk);
        rst = 0; en = 0; br_taken = 0; call = 0; ret = 0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
